udma_rx_channel: RTL and testbench

Single-channel uDMA receive engine that sits between a peripheral's RX stream and the L2 write port. It accepts per-channel configuration: start address, size, continuous mode, enable, and clear. It consumes byte, halfword or word beats from the peripheral, issues byte-enabled L2 writes at incrementing addresses, and reports enable, pending, current address, bytes left and end-of-transfer. It is the channel-side counterpart that terminates a peripheral's `cfg_rx_*` and `data_rx_*` signals.

---
 rtl/udma_ch_pkg.sv | 51 +++++
 rtl/udma_rx_channel_if.sv | 28 ++
 rtl/udma_ch_wbuf.sv | 50 +++++
 rtl/udma_rx_channel.sv | 170 +++++++++++++++++
 tb/tb_udma_rx_channel.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udma_ch_pkg.sv
// rtl/udma_ch_pkg.sv - shared beat-size types and lane helpers for the uDMA channel
//
// Contents:
//   datasize_e  : peripheral beat size code (3 behaves as a word)
//   lane_t      : byte enables plus lane-replicated write data
//   beat_bytes  : bytes carried by one beat (1, 2 or 4)
//   lane_map    : byte enables and replicated data for a beat at a given address
package udma_ch_pkg;

    typedef enum logic [1:0] {
        DS_BYTE = 2'd0,
        DS_HALF = 2'd1,
        DS_WORD = 2'd2
    } datasize_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } lane_t;

    function automatic logic [2:0] beat_bytes(input logic [1:0] ds);
        case (ds)
            DS_BYTE: return 3'd1;
            DS_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Narrow beats are replicated across all lanes so the byte enables alone
    // select the bytes L2 stores; halfwords always land on an even lane pair.
    function automatic lane_t lane_map(input logic [1:0]  ds,
                                       input logic [1:0]  lsb,
                                       input logic [31:0] data);
        lane_t l;
        l.be    = 4'hF;
        l.wdata = data;
        case (ds)
            DS_BYTE: begin
                l.be    = 4'b0001 << lsb;
                l.wdata = {4{data[7:0]}};
            end
            DS_HALF: begin
                l.be    = 4'b0011 << {lsb[1], 1'b0};
                l.wdata = {2{data[15:0]}};
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/udma_rx_channel_if.sv
// rtl/udma_rx_channel_if.sv - peripheral RX beat stream and L2 write port interfaces
//
// udma_rx_data_if : datasize/data/valid from the peripheral (master), ready back
//                   from the channel (slave).
// udma_l2_wr_if   : req/addr/wdata/be from the channel (master), gnt back from
//                   the L2 arbiter (slave).
interface udma_rx_data_if;
    logic [1:0]  datasize;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (output datasize, data, valid, input ready);
    modport slave  (input datasize, data, valid, output ready);
endinterface

interface udma_l2_wr_if #(
    parameter int AW = 12
);
    logic          req;
    logic          gnt;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;

    modport master (output req, addr, wdata, be, input gnt);
    modport slave  (input req, addr, wdata, be, output gnt);
endinterface

// File: rtl/udma_ch_wbuf.sv
// rtl/udma_ch_wbuf.sv - one-entry write buffer from accepted beats to L2 req/gnt
//
// Ports:
//   clk_i, rstn_i                  : clock, asynchronous active-low reset
//   in_valid, in_addr/wdata/be     : write to capture
//   in_ready                       : buffer empty, or draining this cycle
//   l2 (udma_l2_wr_if.master)      : request held stable until granted
module udma_ch_wbuf #(
    parameter int AW = 12
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            in_valid,
    input  logic [AW-1:0]   in_addr,
    input  logic [31:0]     in_wdata,
    input  logic [3:0]      in_be,
    output logic            in_ready,
    udma_l2_wr_if.master    l2
);

    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;

    // A grant in the same cycle as a new write refills without a bubble.
    assign in_ready = ~valid_q | l2.gnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            be_q    <= in_be;
        end else if (l2.gnt) begin
            valid_q <= 1'b0;
        end
    end

    assign l2.req   = valid_q;
    assign l2.addr  = addr_q;
    assign l2.wdata = wdata_q;
    assign l2.be    = be_q;

endmodule

// File: rtl/udma_rx_channel.sv
// rtl/udma_rx_channel.sv - single-channel uDMA RX engine: peripheral beats to L2 writes
//
// Ports:
//   clk_i, rstn_i                    : clock, asynchronous active-low reset
//   cfg_startaddr_i/size_i/continuous_i, cfg_en_i, cfg_clr_i : channel configuration
//   cfg_en_o, cfg_pending_o          : transfer active / second transfer queued
//   cfg_curr_addr_o, cfg_bytes_left_o: next write address, bytes remaining
//   data_rx (udma_rx_data_if.slave)  : peripheral beat stream
//   l2 (udma_l2_wr_if.master)        : byte-enabled L2 write port
//   eot_o                            : one-cycle end-of-transfer pulse
module udma_rx_channel
    import udma_ch_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_size_i,
    input  logic                      cfg_continuous_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    output logic                      cfg_en_o,
    output logic                      cfg_pending_o,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
    output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
    udma_rx_data_if.slave             data_rx,
    udma_l2_wr_if.master              l2,
    output logic                      eot_o
);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    state_e                    state_q, state_d;
    logic [L2_AWIDTH_NOAL-1:0] curr_addr_q, curr_addr_d;
    logic [L2_AWIDTH_NOAL-1:0] start_addr_q, start_addr_d;
    logic [L2_AWIDTH_NOAL-1:0] sh_addr_q, sh_addr_d;
    logic [TRANS_SIZE-1:0]     bytes_left_q, bytes_left_d;
    logic [TRANS_SIZE-1:0]     size_q, size_d;
    logic [TRANS_SIZE-1:0]     sh_size_q, sh_size_d;
    logic                      cont_q, cont_d;
    logic                      sh_cont_q, sh_cont_d;
    logic                      pending_q, pending_d;
    logic                      eot_q, eot_d;

    logic       buf_ready;
    logic       accept;
    logic       last_beat;
    logic       cfg_ok;
    logic [2:0] beat;
    lane_t      lane;

    assign cfg_en_o      = (state_q == ST_ACTIVE);
    assign data_rx.ready = cfg_en_o & buf_ready;
    assign accept        = data_rx.valid & data_rx.ready;
    assign beat          = beat_bytes(data_rx.datasize);
    assign last_beat     = (TRANS_SIZE'(beat) >= bytes_left_q);
    assign cfg_ok        = cfg_en_i & (cfg_size_i != '0);
    assign lane          = lane_map(data_rx.datasize, curr_addr_q[1:0], data_rx.data);

    always_comb begin
        state_d      = state_q;
        curr_addr_d  = curr_addr_q;
        start_addr_d = start_addr_q;
        sh_addr_d    = sh_addr_q;
        bytes_left_d = bytes_left_q;
        size_d       = size_q;
        sh_size_d    = sh_size_q;
        cont_d       = cont_q;
        sh_cont_d    = sh_cont_q;
        pending_d    = pending_q;
        eot_d        = 1'b0;

        if (cfg_clr_i) begin
            state_d      = ST_IDLE;
            pending_d    = 1'b0;
            bytes_left_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (cfg_ok) begin
                state_d      = ST_ACTIVE;
                curr_addr_d  = cfg_startaddr_i;
                start_addr_d = cfg_startaddr_i;
                bytes_left_d = cfg_size_i;
                size_d       = cfg_size_i;
                cont_d       = cfg_continuous_i;
            end
        end else begin
            if (cfg_ok) begin
                sh_addr_d = cfg_startaddr_i;
                sh_size_d = cfg_size_i;
                sh_cont_d = cfg_continuous_i;
                pending_d = 1'b1;
            end
            if (accept) begin
                curr_addr_d  = curr_addr_q + L2_AWIDTH_NOAL'(beat);
                bytes_left_d = last_beat ? '0 : bytes_left_q - TRANS_SIZE'(beat);
                if (last_beat) begin
                    eot_d = 1'b1;
                    // A configuration arriving on the last beat counts as the
                    // queued transfer, so it is taken over directly.
                    if (cfg_ok || pending_q) begin
                        curr_addr_d  = cfg_ok ? cfg_startaddr_i : sh_addr_q;
                        start_addr_d = cfg_ok ? cfg_startaddr_i : sh_addr_q;
                        bytes_left_d = cfg_ok ? cfg_size_i : sh_size_q;
                        size_d       = cfg_ok ? cfg_size_i : sh_size_q;
                        cont_d       = cfg_ok ? cfg_continuous_i : sh_cont_q;
                        pending_d    = 1'b0;
                    end else if (cont_q) begin
                        curr_addr_d  = start_addr_q;
                        bytes_left_d = size_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            curr_addr_q  <= '0;
            start_addr_q <= '0;
            sh_addr_q    <= '0;
            bytes_left_q <= '0;
            size_q       <= '0;
            sh_size_q    <= '0;
            cont_q       <= 1'b0;
            sh_cont_q    <= 1'b0;
            pending_q    <= 1'b0;
            eot_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            curr_addr_q  <= curr_addr_d;
            start_addr_q <= start_addr_d;
            sh_addr_q    <= sh_addr_d;
            bytes_left_q <= bytes_left_d;
            size_q       <= size_d;
            sh_size_q    <= sh_size_d;
            cont_q       <= cont_d;
            sh_cont_q    <= sh_cont_d;
            pending_q    <= pending_d;
            eot_q        <= eot_d;
        end
    end

    assign cfg_pending_o    = pending_q;
    assign cfg_curr_addr_o  = curr_addr_q;
    assign cfg_bytes_left_o = bytes_left_q;
    assign eot_o            = eot_q;

    // A beat accepted in the same cycle as a clear is discarded.
    udma_ch_wbuf #(
        .AW (L2_AWIDTH_NOAL)
    ) u_wbuf (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .in_valid (accept & ~cfg_clr_i),
        .in_addr  (curr_addr_q),
        .in_wdata (lane.wdata),
        .in_be    (lane.be),
        .in_ready (buf_ready),
        .l2       (l2)
    );

endmodule

// File: tb/tb_udma_rx_channel.sv
// tb/tb_udma_rx_channel.sv - randomized self-checking bench for udma_rx_channel
module tb_udma_rx_channel;

    localparam int AW = 12;
    localparam int TS = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] cfg_startaddr = '0;
    logic [TS-1:0] cfg_size = '0;
    logic          cfg_cont = 1'b0;
    logic          cfg_en = 1'b0;
    logic          cfg_clr = 1'b0;
    logic          cfg_en_o;
    logic          cfg_pending_o;
    logic [AW-1:0] curr_addr;
    logic [TS-1:0] bytes_left;
    logic          eot;

    udma_rx_data_if           data_if ();
    udma_l2_wr_if #(.AW(AW))  l2_if ();

    always #5 clk = ~clk;

    udma_rx_channel #(
        .L2_AWIDTH_NOAL (AW),
        .TRANS_SIZE     (TS)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .cfg_startaddr_i  (cfg_startaddr),
        .cfg_size_i       (cfg_size),
        .cfg_continuous_i (cfg_cont),
        .cfg_en_i         (cfg_en),
        .cfg_clr_i        (cfg_clr),
        .cfg_en_o         (cfg_en_o),
        .cfg_pending_o    (cfg_pending_o),
        .cfg_curr_addr_o  (curr_addr),
        .cfg_bytes_left_o (bytes_left),
        .data_rx          (data_if.slave),
        .l2               (l2_if.master),
        .eot_o            (eot)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
    } wr_t;

    int checks = 0;
    int errors = 0;

    // Reference model: active transfer descriptor plus bytes consumed so far,
    // a single overwritable shadow descriptor, and the expected L2 writes.
    int  m_active, m_start, m_size, m_cont, m_off;
    int  m_pend, s_start, s_size, s_cont, m_eot_next;
    int  n_acc, n_eot, n_wr;
    wr_t exp_wr[$];

    task automatic m_reset();
        m_active = 0; m_start = 0; m_size = 0; m_cont = 0; m_off = 0;
        m_pend = 0; s_start = 0; s_size = 0; s_cont = 0; m_eot_next = 0;
        exp_wr.delete();
    endtask

    // Called just after a falling edge with inputs already set; compares every
    // output against the model, then advances the model over the rising edge.
    task automatic tick();
        bit            exp_ready, acc, ok;
        int            n, a;
        logic [AW-1:0] ea;
        logic [TS-1:0] el;
        logic [31:0]   d;
        wr_t           w;
        #1;
        exp_ready = (m_active != 0) && (exp_wr.size() == 0 || l2_if.gnt);
        checks++;
        if (data_if.ready !== exp_ready) begin
            errors++;
            $display("FAIL ready: got %b expected %b at %0t", data_if.ready, exp_ready, $time);
        end
        checks++;
        if (l2_if.req !== (exp_wr.size() != 0)) begin
            errors++;
            $display("FAIL l2_req: got %b expected %b at %0t", l2_if.req, exp_wr.size() != 0, $time);
        end
        if (exp_wr.size() != 0) begin
            checks++;
            if (l2_if.addr !== exp_wr[0].addr || l2_if.be !== exp_wr[0].be || l2_if.wdata !== exp_wr[0].wdata) begin
                errors++;
                $display("FAIL l2_write: got addr %h be %h data %h expected addr %h be %h data %h at %0t",
                         l2_if.addr, l2_if.be, l2_if.wdata, exp_wr[0].addr, exp_wr[0].be, exp_wr[0].wdata, $time);
            end
            if (l2_if.gnt) begin
                void'(exp_wr.pop_front());
                n_wr++;
            end
        end
        checks++;
        if (eot !== (m_eot_next != 0)) begin
            errors++;
            $display("FAIL eot: got %b expected %b at %0t", eot, m_eot_next != 0, $time);
        end
        checks++;
        if (cfg_en_o !== (m_active != 0) || cfg_pending_o !== (m_pend != 0)) begin
            errors++;
            $display("FAIL en_pending: got %b/%b expected %b/%b at %0t", cfg_en_o, cfg_pending_o,
                     m_active != 0, m_pend != 0, $time);
        end
        ea = AW'((m_start + m_off) % 4096);
        el = (m_active != 0) ? TS'(m_size - m_off) : '0;
        checks++;
        if (curr_addr !== ea || bytes_left !== el) begin
            errors++;
            $display("FAIL status: got addr %h left %0d expected addr %h left %0d at %0t",
                     curr_addr, bytes_left, ea, el, $time);
        end
        if (m_eot_next != 0) n_eot++;
        m_eot_next = 0;

        acc = data_if.valid && exp_ready && !cfg_clr;
        ok  = cfg_en && (cfg_size != 0);
        if (cfg_clr) begin
            m_active = 0;
            m_pend   = 0;
        end else if (m_active == 0) begin
            if (ok) begin
                m_active = 1; m_start = int'(cfg_startaddr); m_size = int'(cfg_size);
                m_cont = int'(cfg_cont); m_off = 0;
            end
        end else begin
            if (ok) begin
                s_start = int'(cfg_startaddr); s_size = int'(cfg_size); s_cont = int'(cfg_cont);
                m_pend = 1;
            end
            if (acc) begin
                n = (data_if.datasize == 2'd0) ? 1 : (data_if.datasize == 2'd1) ? 2 : 4;
                a = (m_start + m_off) % 4096;
                d = data_if.data;
                w.addr = AW'(a);
                if (n == 1) begin
                    w.be    = 4'(1 << (a % 4));
                    w.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
                end else if (n == 2) begin
                    w.be    = 4'(3 << (a & 2));
                    w.wdata = {16'd0, d[15:0]} * 32'h0001_0001;
                end else begin
                    w.be    = 4'hF;
                    w.wdata = d;
                end
                exp_wr.push_back(w);
                n_acc++;
                m_off += n;
                if (m_off >= m_size) begin
                    m_eot_next = 1;
                    if (m_pend != 0) begin
                        m_start = s_start; m_size = s_size; m_cont = s_cont; m_off = 0; m_pend = 0;
                    end else if (m_cont != 0) begin
                        m_off = 0;
                    end else begin
                        m_active = 0;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_cfg(input int addr, input int size, input int cont);
        cfg_startaddr = AW'(addr);
        cfg_size      = TS'(size);
        cfg_cont      = (cont != 0);
        cfg_en        = 1'b1;
        data_if.valid = 1'b0;
        tick();
        cfg_en = 1'b0;
    endtask

    // gmode: 0 grant tied high, 1 grant every third cycle, 2 random grant.
    // ds < 0 picks a random beat size every cycle.
    task automatic run_transfer(input string name, input int gmode, input int ds,
                                input int vprob, input int maxcyc);
        int cyc = 0;
        bit done = 0;
        while (!done && cyc < maxcyc) begin
            data_if.valid    = ($urandom_range(99) < vprob);
            data_if.data     = $urandom;
            data_if.datasize = (ds < 0) ? 2'($urandom_range(3)) : 2'(ds);
            l2_if.gnt        = (gmode == 0) ? 1'b1 : (gmode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(1));
            tick();
            cyc++;
            done = (m_active == 0) && (exp_wr.size() == 0) && (m_eot_next == 0);
        end
        data_if.valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: transfer still busy after %0d cycles, required idle", name, cyc);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (cfg_en_o !== 1'b0 || cfg_pending_o !== 1'b0 || curr_addr !== '0 || bytes_left !== '0 ||
            eot !== 1'b0 || l2_if.req !== 1'b0 || data_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got en %b pend %b addr %h left %0d eot %b req %b ready %b, required all 0",
                     cfg_en_o, cfg_pending_o, curr_addr, bytes_left, eot, l2_if.req, data_if.ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_single();
        int w0 = n_wr, e0 = n_eot;
        start_cfg(12'h100, 8, 0);
        run_transfer("single", 0, 2, 100, 50);
        checks++;
        if (n_wr - w0 !== 2 || n_eot - e0 !== 1) begin
            errors++;
            $display("FAIL single_counts: got %0d writes %0d eot, required 2 writes 1 eot", n_wr - w0, n_eot - e0);
        end
    endtask

    task automatic test_byte_backpressure();
        int w0 = n_wr;
        start_cfg(12'h003, 3, 0);
        run_transfer("byte_bp", 1, 0, 100, 60);
        checks++;
        if (n_wr - w0 !== 3) begin
            errors++;
            $display("FAIL byte_bp_writes: got %0d required 3", n_wr - w0);
        end
    endtask

    task automatic test_queued();
        int w0 = n_wr, e0 = n_eot;
        start_cfg(12'h000, 8, 0);
        start_cfg(12'h200, 4, 0);
        checks++;
        if (cfg_pending_o !== 1'b1) begin
            errors++;
            $display("FAIL queued_pending: got %b required 1", cfg_pending_o);
        end
        run_transfer("queued", 0, 2, 100, 50);
        checks++;
        if (n_wr - w0 !== 3 || n_eot - e0 !== 2 || curr_addr !== 12'h204) begin
            errors++;
            $display("FAIL queued_end: got %0d writes %0d eot addr %h, required 3 writes 2 eot addr 204",
                     n_wr - w0, n_eot - e0, curr_addr);
        end
    endtask

    task automatic test_continuous();
        int a0 = n_acc, e0 = n_eot, cyc = 0;
        start_cfg(12'h040, 4, 1);
        l2_if.gnt = 1'b1;
        data_if.datasize = 2'd1;
        while (n_acc - a0 < 6 && cyc < 40) begin
            data_if.valid = (n_acc - a0 < 6) && ($urandom_range(3) != 0);
            data_if.data  = $urandom;
            tick();
            cyc++;
        end
        data_if.valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (n_eot - e0 !== 3 || cfg_en_o !== 1'b1 || curr_addr !== 12'h040) begin
            errors++;
            $display("FAIL continuous: got %0d eot en %b addr %h, required 3 eot en 1 addr 040",
                     n_eot - e0, cfg_en_o, curr_addr);
        end
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        int a0, w0;
        start_cfg(12'h300, 16, 0);
        l2_if.gnt = 1'b0;
        data_if.valid = 1'b1;
        data_if.datasize = 2'd2;
        data_if.data = $urandom;
        tick();
        tick();
        a0 = n_acc;
        w0 = n_wr;
        cfg_clr = 1'b1;
        cfg_en = 1'b1;
        cfg_startaddr = 12'h500;
        cfg_size = 16'd8;
        tick();
        cfg_clr = 1'b0;
        cfg_en = 1'b0;
        tick();
        checks++;
        if (cfg_en_o !== 1'b0 || cfg_pending_o !== 1'b0 || bytes_left !== '0 || l2_if.req !== 1'b1) begin
            errors++;
            $display("FAIL clear_state: got en %b pend %b left %0d req %b, required 0 0 0 1",
                     cfg_en_o, cfg_pending_o, bytes_left, l2_if.req);
        end
        l2_if.gnt = 1'b1;
        repeat (4) tick();
        data_if.valid = 1'b0;
        checks++;
        if (n_wr - w0 !== 1 || n_acc - a0 !== 0) begin
            errors++;
            $display("FAIL clear_drain: got %0d writes %0d accepts, required 1 write 0 accepts",
                     n_wr - w0, n_acc - a0);
        end
    endtask

    task automatic test_reset_mid();
        start_cfg(12'h080, 16, 0);
        l2_if.gnt = 1'b0;
        data_if.valid = 1'b1;
        data_if.datasize = 2'd2;
        data_if.data = $urandom;
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (cfg_en_o !== 1'b0 || cfg_pending_o !== 1'b0 || curr_addr !== '0 || bytes_left !== '0 ||
            eot !== 1'b0 || l2_if.req !== 1'b0 || data_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got en %b pend %b addr %h left %0d eot %b req %b ready %b, required all 0",
                     cfg_en_o, cfg_pending_o, curr_addr, bytes_left, eot, l2_if.req, data_if.ready);
        end
        m_reset();
        data_if.valid = 1'b0;
        l2_if.gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        start_cfg(12'h123, 0, 0);
        data_if.valid = 1'b1;
        repeat (4) tick();
        data_if.valid = 1'b0;
        checks++;
        if (cfg_en_o !== 1'b0 || l2_if.req !== 1'b0) begin
            errors++;
            $display("FAIL zero_size: got en %b req %b, required 0 0", cfg_en_o, l2_if.req);
        end
    endtask

    task automatic test_random();
        start_cfg(12'hFFE, 4, 0);
        run_transfer("wrap", 0, 1, 100, 40);
        for (int i = 0; i < 8; i++) begin
            start_cfg($urandom_range(4095), $urandom_range(12, 1), 0);
            run_transfer("random", 2, -1, 70, 200);
        end
    endtask

    initial begin
        m_reset();
        n_acc = 0; n_eot = 0; n_wr = 0;
        data_if.valid = 1'b0;
        data_if.data = '0;
        data_if.datasize = 2'd0;
        l2_if.gnt = 1'b1;
        @(negedge clk);
        #1;
        test_reset();
        test_single();
        test_byte_backpressure();
        test_queued();
        test_continuous();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
